// File: rtl/alu_mult_seq_if.sv
// Bus between the EX-stage multiply sequencer and its surroundings:
// the start/busy/done handshake with the pipeline, and the operand/result
// wires to the shared 64-bit ALU.
interface alu_mult_seq_if;
    logic        start;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [2:0]  alu_cntrl;
    logic [63:0] alu_result;
    logic        alu_carry_out;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        product_ovf;

    // Sequencer side
    modport slave (
        input  start, multiplicand, multiplier, alu_result, alu_carry_out,
        output alu_a, alu_b, alu_cntrl, busy, done, product, product_ovf
    );

    // Pipeline / ALU side
    modport master (
        output start, multiplicand, multiplier, alu_result, alu_carry_out,
        input  alu_a, alu_b, alu_cntrl, busy, done, product, product_ovf
    );
endinterface

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: unsigned 64x64 -> low-64 shift-add multiply sequencer.
// Owns no adder; it borrows the shared EX-stage ALU by driving A/B/cntrl
// and captures result/carry_out once per iteration, after SETTLE_CYCLES.
// Optional macro MULT_EARLY_TERM_EN: stop iterating as soon as the
// remaining multiplier bits are all zero (same product and overflow).
module alu_mult_seq #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [2:0]  ALU_ADD_OP    = 3'b010,
    parameter logic [2:0]  ALU_PASS_B_OP = 3'b000
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_mult_seq_if.slave bus
);
    localparam int unsigned   SW            = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

    state_t        r_state;
    logic [63:0]   r_acc;
    logic [63:0]   r_mcand;
    logic [63:0]   r_mplr;
    logic [63:0]   r_product;
    logic [5:0]    r_iter;
    logic [SW-1:0] r_settle;
    logic          r_lost;
    logic          r_ovf;
    logic          r_product_ovf;
    logic          r_done;

    logic [63:0]   w_acc_nxt;
    logic [63:0]   w_mplr_nxt;
    logic          w_ovf_nxt;
    logic          w_last;

    // Values committed at an iteration boundary. A set multiplier bit
    // overflows if the add carries, or if any multiplicand bit already
    // fell off the top (that partial product is >= 2^64 by itself).
    assign w_acc_nxt  = r_mplr[0] ? bus.alu_result : r_acc;
    assign w_ovf_nxt  = r_ovf | (r_mplr[0] & (bus.alu_carry_out | r_lost));
    assign w_mplr_nxt = r_mplr >> 1;
`ifdef MULT_EARLY_TERM_EN
    assign w_last     = (r_iter == 6'd63) || (w_mplr_nxt == 64'd0);
`else
    assign w_last     = (r_iter == 6'd63);
`endif

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.product     = r_product;
    assign bus.product_ovf = r_product_ovf;

    // ALU is only borrowed while iterating; otherwise it passes B=0 so the
    // ALU reads zero with its zero flag set.
    always_comb begin
        bus.alu_a     = 64'd0;
        bus.alu_b     = 64'd0;
        bus.alu_cntrl = ALU_PASS_B_OP;
        if (r_state == S_ITER) begin
            bus.alu_a     = r_acc;
            bus.alu_b     = r_mcand;
            bus.alu_cntrl = ALU_ADD_OP;
        end
    end

    // Sequencer FSM; product/ovf are loaded on the edge entering DONE so
    // they are already valid in the done cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_acc         <= 64'd0;
            r_mcand       <= 64'd0;
            r_mplr        <= 64'd0;
            r_product     <= 64'd0;
            r_iter        <= 6'd0;
            r_settle      <= '0;
            r_lost        <= 1'b0;
            r_ovf         <= 1'b0;
            r_product_ovf <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_acc    <= 64'd0;
                    r_mcand  <= bus.multiplicand;
                    r_mplr   <= bus.multiplier;
                    r_iter   <= 6'd0;
                    r_lost   <= 1'b0;
                    r_ovf    <= 1'b0;
                    r_settle <= SETTLE_RELOAD;
                    r_state  <= S_ITER;
`ifdef MULT_EARLY_TERM_EN
                    if (bus.multiplier == 64'd0) begin
                        r_state       <= S_DONE;
                        r_done        <= 1'b1;
                        r_product     <= 64'd0;
                        r_product_ovf <= 1'b0;
                    end
`endif
                end
                S_ITER: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - SW'(1);
                    end else begin
                        r_acc    <= w_acc_nxt;
                        r_ovf    <= w_ovf_nxt;
                        r_lost   <= r_lost | r_mcand[63];
                        r_mcand  <= r_mcand << 1;
                        r_mplr   <= w_mplr_nxt;
                        r_settle <= SETTLE_RELOAD;
                        r_iter   <= r_iter + 6'd1;
                        if (w_last) begin
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_product     <= w_acc_nxt;
                            r_product_ovf <= w_ovf_nxt;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
